var_base_cell: RTL and testbench

- Per-variable base cell at the foot of one column of the clause array.
- Holds the variable's assignment, its decision level and its implied/decided origin.
- Broadcasts the current value up the column to every literal cell.
- Collects and merges the literal cells' implication and conflict returns, then commits implications, flags conflicts and clears the assignment on backtrack.

---
 rtl/sat_pkg.sv | 19 +
 rtl/var_return_merge.sv | 22 ++
 rtl/var_base_cell.sv | 133 +++++++++++++
 tb/tb_var_base_cell.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// Shared encodings and types for the clause-array column: value codes,
// the 3-bit column bus and the default decision-level width.
package sat_pkg;

    localparam logic [1:0] VAL_FREE     = 2'b00;
    localparam logic [1:0] VAL_FALSE    = 2'b01;
    localparam logic [1:0] VAL_TRUE     = 2'b10;
    localparam logic [1:0] VAL_CONFLICT = 2'b11;

    localparam int DEFAULT_LVL_W = 4;

    // Column bus: [2:1] value, [0] implied / implication-drive flag
    typedef logic [2:0] col_bus_t;

    function automatic logic is_bool(input logic [1:0] v);
        return (v == VAL_TRUE) || (v == VAL_FALSE);
    endfunction

endpackage

// File: rtl/var_return_merge.sv
// OR-merges the per-row returns of one column into a single value and drive
// flag. Opposite polarities from two rows OR together into VAL_CONFLICT.
module var_return_merge
    import sat_pkg::*;
#(
    parameter int NUM_CLAUSES = 8
) (
    input  logic [3*NUM_CLAUSES-1:0] ret_i,
    output logic [1:0]               m_val_o,
    output logic                     m_drv_o
);

    always_comb begin
        m_val_o = VAL_FREE;
        m_drv_o = 1'b0;
        for (int i = 0; i < NUM_CLAUSES; i++) begin
            m_val_o = m_val_o | ret_i[3*i+1 +: 2];
            m_drv_o = m_drv_o | ret_i[3*i];
        end
    end

endmodule

// File: rtl/var_base_cell.sv
// Per-variable base cell at the foot of a clause-array column: holds the
// assignment, broadcasts it upward and commits merged implications/conflicts.
// Optional activity counter enabled by VAR_BASE_CELL_ACTIVITY_EN.
module var_base_cell
    import sat_pkg::*;
#(
    parameter int NUM_CLAUSES = 8,
    parameter int LVL_W       = DEFAULT_LVL_W,
    parameter int ACT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_i,
    input  logic [1:0]               load_value_i,
    input  logic                     decide_i,
    input  logic [1:0]               decide_value_i,
    input  logic [LVL_W-1:0]         cur_level_i,
    input  logic                     backtrack_i,
    input  logic [LVL_W-1:0]         bt_level_i,
    input  logic [3*NUM_CLAUSES-1:0] var_value_tobase_i,
    output logic [2:0]               var_value_frombase_o,
    output logic                     assigned_o,
    output logic                     implied_o,
    output logic [LVL_W-1:0]         level_o,
    output logic                     conflict_o,
    output logic                     imp_o
`ifdef VAR_BASE_CELL_ACTIVITY_EN
    ,
    input  logic                     decay_i,
    output logic [ACT_W-1:0]         activity_o
`endif
);

    logic [1:0]       m_val;
    logic             m_drv;

    logic [1:0]       value_q, value_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             implied_q, implied_d;
    logic             conflict_q, conflict_d;
    logic             imp_q, imp_d;
    logic             assigned;

    var_return_merge #(
        .NUM_CLAUSES(NUM_CLAUSES)
    ) u_merge (
        .ret_i  (var_value_tobase_i),
        .m_val_o(m_val),
        .m_drv_o(m_drv)
    );

    assign assigned = (value_q != VAL_FREE);

    always_comb begin
        value_d    = value_q;
        level_d    = level_q;
        implied_d  = implied_q;
        conflict_d = 1'b0;
        imp_d      = 1'b0;
        if (load_i) begin
            // write phase: column bus is borrowed, state frozen
        end else if (backtrack_i) begin
            if (assigned && (level_q > bt_level_i)) begin
                value_d   = VAL_FREE;
                level_d   = '0;
                implied_d = 1'b0;
            end
        end else begin
            conflict_d = (m_val == VAL_CONFLICT);
            if (!assigned) begin
                if (decide_i) begin
                    if (is_bool(decide_value_i)) begin
                        value_d   = decide_value_i;
                        level_d   = cur_level_i;
                        implied_d = 1'b0;
                    end
                end else if (m_drv && is_bool(m_val)) begin
                    value_d   = m_val;
                    level_d   = cur_level_i;
                    implied_d = 1'b1;
                    imp_d     = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q    <= VAL_FREE;
            level_q    <= '0;
            implied_q  <= 1'b0;
            conflict_q <= 1'b0;
            imp_q      <= 1'b0;
        end else begin
            value_q    <= value_d;
            level_q    <= level_d;
            implied_q  <= implied_d;
            conflict_q <= conflict_d;
            imp_q      <= imp_d;
        end
    end

    assign var_value_frombase_o = load_i ? {load_value_i, 1'b0} : {value_q, implied_q};
    assign assigned_o           = assigned;
    assign implied_o            = implied_q;
    assign level_o              = level_q;
    assign conflict_o           = conflict_q;
    assign imp_o                = imp_q;

`ifdef VAR_BASE_CELL_ACTIVITY_EN
    logic [ACT_W-1:0] act_q, act_d;

    // decay wins over a same-cycle increment
    always_comb begin
        act_d = act_q;
        if (decay_i)
            act_d = act_q >> 1;
        else if (conflict_q && (act_q != {ACT_W{1'b1}}))
            act_d = act_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) act_q <= '0;
        else     act_q <= act_d;
    end

    assign activity_o = act_q;
`else
    logic [ACT_W-1:0] act_unused;
    assign act_unused = '0;
`endif

endmodule

// File: tb/tb_var_base_cell.sv
// Directed, scoreboard-driven bench for var_base_cell: expected column state
// is queued with each stimulus step and checked after the DUT responds.
module tb_var_base_cell;
    import sat_pkg::*;

    localparam int NC    = 8;
    localparam int LVL_W = 4;
    localparam int ACT_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               load_i;
    logic [1:0]         load_value_i;
    logic               decide_i;
    logic [1:0]         decide_value_i;
    logic [LVL_W-1:0]   cur_level_i;
    logic               backtrack_i;
    logic [LVL_W-1:0]   bt_level_i;
    logic [3*NC-1:0]    tobase;
    logic [2:0]         frombase;
    logic               assigned_o, implied_o, conflict_o, imp_o;
    logic [LVL_W-1:0]   level_o;
`ifdef VAR_BASE_CELL_ACTIVITY_EN
    logic               decay_i;
    logic [ACT_W-1:0]   activity_o;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        string            tag;
        logic [2:0]       fb;
        logic             asg;
        logic             impl;
        logic [LVL_W-1:0] lvl;
        logic             cf;
        logic             ip;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    var_base_cell #(.NUM_CLAUSES(NC), .LVL_W(LVL_W), .ACT_W(ACT_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .load_i              (load_i),
        .load_value_i        (load_value_i),
        .decide_i            (decide_i),
        .decide_value_i      (decide_value_i),
        .cur_level_i         (cur_level_i),
        .backtrack_i         (backtrack_i),
        .bt_level_i          (bt_level_i),
        .var_value_tobase_i  (tobase),
        .var_value_frombase_o(frombase),
        .assigned_o          (assigned_o),
        .implied_o           (implied_o),
        .level_o             (level_o),
        .conflict_o          (conflict_o),
        .imp_o               (imp_o)
`ifdef VAR_BASE_CELL_ACTIVITY_EN
        ,
        .decay_i             (decay_i),
        .activity_o          (activity_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] fb, input logic asg,
                        input logic impl, input logic [LVL_W-1:0] lvl,
                        input logic cf, input logic ip);
        exp_t e;
        e.tag = tag; e.fb = fb; e.asg = asg; e.impl = impl;
        e.lvl = lvl; e.cf = cf; e.ip = ip;
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".frombase"}, {29'd0, frombase},   {29'd0, e.fb});
            chk({e.tag, ".assigned"}, {31'd0, assigned_o}, {31'd0, e.asg});
            chk({e.tag, ".implied"},  {31'd0, implied_o},  {31'd0, e.impl});
            chk({e.tag, ".level"},    {28'd0, level_o},    {28'd0, e.lvl});
            chk({e.tag, ".conflict"}, {31'd0, conflict_o}, {31'd0, e.cf});
            chk({e.tag, ".imp"},      {31'd0, imp_o},      {31'd0, e.ip});
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        check_now();
    endtask

    task automatic idle();
        load_i = 0; load_value_i = VAL_FREE; decide_i = 0; decide_value_i = VAL_FREE;
        backtrack_i = 0; bt_level_i = '0; tobase = '0;
`ifdef VAR_BASE_CELL_ACTIVITY_EN
        decay_i = 0;
`endif
    endtask

    task automatic set_row(input int r, input logic [2:0] v);
        tobase[3*r +: 3] = v;
    endtask

    initial begin
        idle();
        cur_level_i = '0;
        rst = 1'b1;
        #12;
        push("reset", 3'b000, 0, 0, 0, 0, 0);
        check_now();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // load: bus shows load value same cycle; even a conflicting return is ignored
        load_i = 1; load_value_i = VAL_TRUE;
        set_row(0, 3'b011); set_row(1, 3'b101);
        #1;
        push("load_comb", 3'b100, 0, 0, 0, 0, 0);
        check_now();
        push("load_hold", 3'b100, 0, 0, 0, 0, 0);
        cycle();
        idle();
        #1;
        push("load_release", 3'b000, 0, 0, 0, 0, 0);
        check_now();

        // decide TRUE at level 3
        decide_i = 1; decide_value_i = VAL_TRUE; cur_level_i = 4'd3;
        push("decide", 3'b100, 1, 0, 3, 0, 0);
        cycle();
        decide_value_i = VAL_FALSE; cur_level_i = 4'd7;
        push("decide_while_assigned", 3'b100, 1, 0, 3, 0, 0);
        cycle();
        idle();
        backtrack_i = 1; bt_level_i = 4'd3;
        push("bt_same_level_hold", 3'b100, 1, 0, 3, 0, 0);
        cycle();
        bt_level_i = 4'd2;
        push("bt_clear", 3'b000, 0, 0, 0, 0, 0);
        cycle();
        idle();

        // implication FALSE from row 2 at level 5
        set_row(2, 3'b011); cur_level_i = 4'd5;
        push("implication", 3'b011, 1, 1, 5, 0, 1);
        cycle();
        idle();
        push("imp_pulse_end", 3'b011, 1, 1, 5, 0, 0);
        cycle();
        backtrack_i = 1; bt_level_i = 4'd4;
        push("bt_clear_implied", 3'b000, 0, 0, 0, 0, 0);
        cycle();
        idle();

        // opposite implications from two rows -> conflict, no commit
        set_row(0, 3'b101); set_row(7, 3'b011);
        push("conflict", 3'b000, 0, 0, 0, 1, 0);
        cycle();
        idle();
        push("conflict_pulse_end", 3'b000, 0, 0, 0, 0, 0);
        cycle();

        // backtrack suppresses same-cycle implication and conflict
        backtrack_i = 1; bt_level_i = 4'd0; set_row(3, 3'b101);
        push("bt_drops_imp", 3'b000, 0, 0, 0, 0, 0);
        cycle();
        set_row(4, 3'b011);
        push("bt_drops_conflict", 3'b000, 0, 0, 0, 0, 0);
        cycle();
        idle();

        // non-driving return alone does not commit
        set_row(5, 3'b100);
        push("no_drive_no_commit", 3'b000, 0, 0, 0, 0, 0);
        cycle();
        idle();

        // decide beats a same-cycle implication
        decide_i = 1; decide_value_i = VAL_FALSE; cur_level_i = 4'd2; set_row(6, 3'b101);
        push("decide_over_imp", 3'b010, 1, 0, 2, 0, 0);
        cycle();
        idle();
        backtrack_i = 1; bt_level_i = 4'd1;
        push("bt_clear2", 3'b000, 0, 0, 0, 0, 0);
        cycle();
        idle();

        // async reset between edges after a decision
        decide_i = 1; decide_value_i = VAL_TRUE; cur_level_i = 4'd3;
        push("pre_reset_decide", 3'b100, 1, 0, 3, 0, 0);
        cycle();
        idle();
        set_row(1, 3'b011);
        #2 rst = 1'b1;
        #1;
        push("async_reset", 3'b000, 0, 0, 0, 0, 0);
        check_now();
        #2 rst = 1'b0;
        idle();
        push("after_reset_idle", 3'b000, 0, 0, 0, 0, 0);
        cycle();

`ifdef VAR_BASE_CELL_ACTIVITY_EN
        chk("act_reset", {24'd0, activity_o}, 32'd0);
        set_row(0, 3'b101); set_row(1, 3'b011);
        repeat (3) begin
            push("act_conflict", 3'b000, 0, 0, 0, 1, 0);
            cycle();
        end
        idle();
        push("act_conflict_tail", 3'b000, 0, 0, 0, 0, 0);
        cycle();
        chk("act_three", {24'd0, activity_o}, 32'd3);
        decay_i = 1;
        @(posedge clk); #1;
        decay_i = 0;
        chk("act_decay", {24'd0, activity_o}, 32'd1);
        set_row(0, 3'b101); set_row(1, 3'b011);
        repeat (260) @(posedge clk);
        #1;
        chk("act_saturate", {24'd0, activity_o}, 32'd255);
        @(posedge clk); #1;
        chk("act_stay_sat", {24'd0, activity_o}, 32'd255);
        decay_i = 1;
        @(posedge clk); #1;
        chk("act_decay_over_inc", {24'd0, activity_o}, 32'd127);
        idle();
`endif

        if (sb.size() != 0) chk("scoreboard_leftover", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
